axil_regfile_slave: RTL and testbench

Parametrised AXI4-Lite slave register file, the next generation of the team's fixed 4-register AXI-Lite slave. Provides NUM_REGS byte-strobed registers, accepts AW and W independently in either order, returns BRESP/RRESP, and flags out-of-range accesses. Sits behind the system AXI-Lite interconnect as the control/status register bank of a peripheral.

---
 rtl/axil_regfile_slave.sv | 202 ++++++++++++++++++++
 tb/tb_axil_regfile_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_regfile_slave.sv
// AXI4-Lite register file: NUM_REGS byte-strobed registers, AW/W accepted independently in any order.
// Optional feature macro AXIL_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_regfile_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - LSB;

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    typedef enum logic {W_COLLECT, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA}    rd_state_t;

    wr_state_t wstate;
    rd_state_t rstate;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // One-entry holding registers for whichever of AW/W arrives first
    logic                  aw_held;
    logic [IDX_W-1:0]      aw_idx_q;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_avail;
    logic                  w_avail;
    logic                  wr_fire;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [NUM_REGS-1:0]   wr_sel;
    logic                  wr_in_range;

    logic [IDX_W-1:0]      rd_idx;
    logic [NUM_REGS-1:0]   rd_sel;
    logic                  rd_in_range;
    logic [DATA_WIDTH-1:0] rd_val;

    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

    assign aw_hs    = AWVALID && AWREADY;
    assign w_hs     = WVALID && WREADY;
    assign aw_avail = aw_held || aw_hs;
    assign w_avail  = w_held || w_hs;
    assign wr_fire  = (wstate == W_COLLECT) && aw_avail && w_avail;

    assign wr_idx  = aw_held ? aw_idx_q : AWADDR[ADDR_WIDTH-1:LSB];
    assign wr_data = w_held ? w_data_q : WDATA;
    assign wr_strb = w_held ? w_strb_q : WSTRB;
    assign rd_idx  = ARADDR[ADDR_WIDTH-1:LSB];

    // One-hot decode; an index matching no register is out of range
    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i] = (wr_idx == IDX_W'(i));
            rd_sel[i] = (rd_idx == IDX_W'(i));
        end
    end

    assign wr_in_range = |wr_sel;
    assign rd_in_range = |rd_sel;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_sel[i]) begin
                rd_val = regs[i];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_fire) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_sel[i] && wr_strb[b]) begin
                        regs[i][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wstate   <= W_COLLECT;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BRESP    <= RESP_OKAY;
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            case (wstate)
                W_COLLECT: begin
                    if (wr_fire) begin
                        aw_held <= 1'b0;
                        w_held  <= 1'b0;
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b0;
                        BVALID  <= 1'b1;
                        BRESP   <= wr_in_range ? RESP_OKAY : RESP_OOR;
                        wstate  <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_held  <= 1'b1;
                            aw_idx_q <= AWADDR[ADDR_WIDTH-1:LSB];
                        end
                        if (w_hs) begin
                            w_held   <= 1'b1;
                            w_data_q <= WDATA;
                            w_strb_q <= WSTRB;
                        end
                        AWREADY <= !aw_avail;
                        WREADY  <= !w_avail;
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        WREADY  <= 1'b1;
                        wstate  <= W_COLLECT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            rstate  <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
        end else begin
            case (rstate)
                R_IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        RDATA   <= rd_val;
                        RRESP   <= rd_in_range ? RESP_OKAY : RESP_OOR;
                        RVALID  <= 1'b1;
                        ARREADY <= 1'b0;
                        rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        ARREADY <= 1'b1;
                        rstate  <= R_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Bench for axil_regfile_slave: transaction-level register model plus per-cycle response scoreboard.
module tb_axil_regfile_slave;

    localparam int NREG = 16;
`ifdef AXIL_SLVERR_EN
    localparam logic [1:0] OOR = 2'b10;
`else
    localparam logic [1:0] OOR = 2'b00;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [7:0]  AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [7:0]  ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;

    axil_regfile_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mregs [NREG];
    logic [1:0]  exp_b [$];
    logic [31:0] exp_rd [$];
    logic [1:0]  exp_rr [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        exp_b.delete();
        exp_rd.delete();
        exp_rr.delete();
    endtask

    // Scoreboard: any valid response must match the model's head entry every cycle it is shown
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (BVALID) begin
                if (exp_b.size() == 0) fail_evt("b_unexpected");
                else begin
                    check("bresp", BRESP, exp_b[0]);
                    if (BREADY) void'(exp_b.pop_front());
                end
            end
            if (RVALID) begin
                if (exp_rd.size() == 0) fail_evt("r_unexpected");
                else begin
                    check("rdata", RDATA, exp_rd[0]);
                    check("rresp", RRESP, exp_rr[0]);
                    if (RREADY) begin
                        void'(exp_rd.pop_front());
                        void'(exp_rr.pop_front());
                    end
                end
            end
        end
    end

    // lead > 0 delays AW by that many cycles after W; lead < 0 delays W after AW
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input int b_delay);
        int idx;
        bit aw_done;
        bit w_done;
        idx = int'(a) / 4;
        if (idx < NREG) begin
            for (int b = 0; b < 4; b++) if (s[b]) mregs[idx][8*b +: 8] = d[8*b +: 8];
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(OOR);
        end
        aw_done = 0;
        w_done  = 0;
        fork
            begin
                int n;
                for (int k = 0; k < -lead; k++) begin
                    @(negedge ACLK);
                    check("b_early", BVALID, 0);
                    if (aw_done) check("aw_blocked_early", AWREADY, 0);
                end
                if (lead < 0) @(posedge ACLK) #1;
                WDATA = d; WSTRB = s; WVALID = 1'b1;
                n = 0;
                while (1) begin
                    @(negedge ACLK);
                    if (WREADY) break;
                    n++;
                    if (n > 50) begin fail_evt("w_timeout"); break; end
                end
                @(posedge ACLK);
                w_done = 1;
                #1 WVALID = 1'b0;
            end
            begin
                int n;
                for (int k = 0; k < lead; k++) begin
                    @(negedge ACLK);
                    check("b_early", BVALID, 0);
                    if (w_done) check("w_blocked_early", WREADY, 0);
                end
                if (lead > 0) @(posedge ACLK) #1;
                AWADDR = a; AWVALID = 1'b1;
                n = 0;
                while (1) begin
                    @(negedge ACLK);
                    if (AWREADY) break;
                    n++;
                    if (n > 50) begin fail_evt("aw_timeout"); break; end
                end
                @(posedge ACLK);
                aw_done = 1;
                #1 AWVALID = 1'b0;
            end
        join
        @(negedge ACLK);
        check("b_latency", BVALID, 1);
        for (int k = 0; k < b_delay; k++) begin
            check("aw_blocked", AWREADY, 0);
            check("w_blocked", WREADY, 0);
            @(negedge ACLK);
            check("b_hold", BVALID, 1);
        end
        @(posedge ACLK);
        #1 BREADY = 1'b1;
        @(posedge ACLK);
        #1 BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx;
        int n;
        idx = int'(a) / 4;
        exp_rd.push_back(idx < NREG ? mregs[idx] : 32'h0);
        exp_rr.push_back(idx < NREG ? 2'b00 : OOR);
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (1) begin
            @(negedge ACLK);
            if (ARREADY) break;
            n++;
            if (n > 50) begin fail_evt("ar_timeout"); break; end
        end
        @(posedge ACLK);
        #1 ARVALID = 1'b0; RREADY = 1'b1;
        @(negedge ACLK);
        check("r_latency", RVALID, 1);
        d = RDATA;
        r = RRESP;
        @(posedge ACLK);
        #1 RREADY = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int n;

        model_reset();
        ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_bresp", BRESP, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_rdata", RDATA, 0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        check("ready_before_edge", ARREADY, 0);
        @(negedge ACLK);
        check("awready_up", AWREADY, 1);
        check("wready_up", WREADY, 1);
        check("arready_up", ARREADY, 1);
        @(posedge ACLK);
        #1;

        for (int i = 0; i < NREG; i++) begin
            axi_read(8'(4 * i), d, r);
            check("reset_reg_zero", d, 0);
        end

        axi_write(8'h04, 32'h12345678, 4'hF, 0, 0);
        axi_read(8'h04, d, r);
        check("full_write", d, 32'h12345678);

        axi_write(8'h08, 32'h11223344, 4'hF, 0, 0);
        axi_write(8'h08, 32'hDEADBEEF, 4'b1100, 0, 0);
        axi_read(8'h08, d, r);
        check("byte_strobe", d, 32'hDEAD3344);

        axi_write(8'h0C, 32'hA5A5A5A5, 4'hF, 3, 4);
        axi_read(8'h0C, d, r);
        check("w_before_aw", d, 32'hA5A5A5A5);

        axi_write(8'h10, 32'h5A5A0FF0, 4'hF, -2, 1);
        axi_read(8'h10, d, r);
        check("aw_before_w", d, 32'h5A5A0FF0);

        axi_write(8'h04, 32'hFFFFFFFF, 4'h0, 0, 0);
        axi_read(8'h04, d, r);
        check("zero_strobe", d, 32'h12345678);

        axi_write(8'h17, 32'h01020304, 4'hF, 0, 0);
        axi_read(8'h14, d, r);
        check("unaligned", d, 32'h01020304);

        axi_write(8'h40, 32'hFFFFFFFF, 4'hF, 0, 2);
        axi_read(8'h40, d, r);
        check("oor_rdata", d, 0);
        check("oor_rresp", r, OOR);
        for (int i = 0; i < NREG; i++) axi_read(8'(4 * i), d, r);

        check("model_reg1", mregs[1], 32'h12345678);
        check("model_reg2", mregs[2], 32'hDEAD3344);
        check("model_reg3", mregs[3], 32'hA5A5A5A5);
        check("model_reg5", mregs[5], 32'h01020304);

        // Reset while AW is held and W is being offered
        AWADDR = 8'h14; AWVALID = 1'b1;
        n = 0;
        while (1) begin
            @(negedge ACLK);
            if (AWREADY) break;
            n++;
            if (n > 50) begin fail_evt("aw_timeout"); break; end
        end
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
        WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1; ARESETn = 1'b0;
        model_reset();
        repeat (2) @(posedge ACLK);
        #1 WVALID = 1'b0; ARESETn = 1'b1;
        @(negedge ACLK);
        check("rst_mid_bvalid", BVALID, 0);
        @(posedge ACLK);
        #1;
        axi_write(8'h18, 32'h0BADBEEF, 4'hF, 3, 0);
        axi_read(8'h14, d, r);
        check("rst_mid_target", d, 0);
        axi_read(8'h18, d, r);
        check("post_rst_write", d, 32'h0BADBEEF);

        check("b_queue_drained", exp_b.size(), 0);
        check("r_queue_drained", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
